// File: rtl/top6_pkg.sv
// rtl/top6_pkg.sv - shared widths, entry format and FSM states for the top-6 stream sorter
package top6_pkg;
    localparam int VAL_W = 8;
    localparam int IDX_W = 5;
    localparam int K     = 6;
    localparam int N     = 2 ** IDX_W;
    localparam int CNT_W = $clog2(K + 1);

    // Field order matches the packed {value, index} output word
    typedef struct packed {
        logic signed [VAL_W-1:0] value;
        logic [IDX_W-1:0]        idx;
    } entry_t;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;
endpackage

// File: rtl/rank_slot.sv
// rtl/rank_slot.sv - one ranked entry of the sorted list; inserts, shifts down or holds
module rank_slot
    import top6_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_clear,
    input  logic   i_insert_en,
    input  entry_t i_new,
    input  entry_t i_up_entry,
    input  logic   i_up_valid,
    input  logic   i_up_gt,
    output entry_t o_entry,
    output logic   o_valid,
    output logic   o_gt
);
    entry_t r_entry;
    logic   r_valid;

    // Ties are not "greater", so an earlier arrival keeps its rank
    assign o_gt    = !r_valid || ($signed(i_new.value) > $signed(r_entry.value));
    assign o_entry = r_entry;
    assign o_valid = r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_entry <= '0;
            r_valid <= 1'b0;
        end else if (i_insert_en) begin
            if (i_up_gt) begin
                r_entry <= i_up_entry;
                r_valid <= i_up_valid;
            end else if (o_gt) begin
                r_entry <= i_new;
                r_valid <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/top6_stream_sorter.sv
// rtl/top6_stream_sorter.sv - keeps the six largest values of a frame and drains them as {value, index} words
module top6_stream_sorter
    import top6_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [VAL_W-1:0]       in_value,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [VAL_W+IDX_W-1:0] out_data,
    output logic                          out_last
);
    state_t           r_state;
    logic [IDX_W-1:0] r_idx_cnt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_rd_ptr;

    entry_t w_entry [K];
    logic   w_valid [K];
    logic   w_gt    [K];
    entry_t w_new;
    entry_t w_sel;
    logic   w_in_hs;
    logic   w_update;
    logic   w_frame_end;
    logic   w_out_hs;
    logic   w_done;

    assign w_new       = '{value: in_value, idx: r_idx_cnt};
    assign w_in_hs     = in_valid && (r_state == LOAD);
    // A value below every full slot would only hold all slots, so skip the update
    assign w_update    = w_in_hs && w_gt[K-1];
    assign w_frame_end = w_in_hs && (in_last || (&r_idx_cnt));
    assign w_out_hs    = out_valid && out_ready;
    assign w_done      = w_out_hs && out_last;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_slot
            if (gi == 0) begin : g_head
                rank_slot u_slot (
                    .clk        (clk),
                    .rst_n      (rst_n),
                    .i_clear    (w_done),
                    .i_insert_en(w_update),
                    .i_new      (w_new),
                    .i_up_entry ('0),
                    .i_up_valid (1'b0),
                    .i_up_gt    (1'b0),
                    .o_entry    (w_entry[gi]),
                    .o_valid    (w_valid[gi]),
                    .o_gt       (w_gt[gi])
                );
            end else begin : g_tail
                rank_slot u_slot (
                    .clk        (clk),
                    .rst_n      (rst_n),
                    .i_clear    (w_done),
                    .i_insert_en(w_update),
                    .i_new      (w_new),
                    .i_up_entry (w_entry[gi-1]),
                    .i_up_valid (w_valid[gi-1]),
                    .i_up_gt    (w_gt[gi-1]),
                    .o_entry    (w_entry[gi]),
                    .o_valid    (w_valid[gi]),
                    .o_gt       (w_gt[gi])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= LOAD;
            r_idx_cnt <= '0;
            r_count   <= '0;
            r_rd_ptr  <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_in_hs) begin
                        r_idx_cnt <= r_idx_cnt + 1'b1;
                        // Slots fill top-down, so an empty last slot means not yet full
                        if (!w_valid[K-1]) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (w_frame_end) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_out_hs) begin
                        if (out_last) begin
                            r_state   <= LOAD;
                            r_idx_cnt <= '0;
                            r_count   <= '0;
                            r_rd_ptr  <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign w_sel     = w_entry[r_rd_ptr];
    assign in_ready  = (r_state == LOAD);
    assign out_valid = (r_state == DRAIN);
    assign out_data  = (r_state == DRAIN) ? w_sel : '0;
    assign out_last  = (r_state == DRAIN) && (r_rd_ptr == r_count - 1'b1);
endmodule

// File: tb/tb_top6_stream_sorter.sv
// tb/tb_top6_stream_sorter.sv - randomized and directed self-checking bench for top6_stream_sorter
module tb_top6_stream_sorter;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] in_value = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic signed [12:0] out_data;
    logic              out_last;

    top6_stream_sorter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  fv [32];
    logic [12:0] exp_q [$];
    logic [12:0] got_q [$];
    int          last_pos;
    int          stall_err;
    bit          drain_to;
    bit          send_to;

    // Reference: repeatedly pick the largest unused value, earliest index on ties
    function automatic void build_expected(input int n);
        bit used [32];
        int best;
        exp_q.delete();
        for (int j = 0; j < 32; j++) used[j] = 1'b0;
        for (int k = 0; k < ((n < 6) ? n : 6); k++) begin
            best = -1;
            for (int j = 0; j < n; j++) begin
                if (!used[j] && (best < 0 || $signed(fv[j]) > $signed(fv[best]))) best = j;
            end
            used[best] = 1'b1;
            exp_q.push_back({fv[best], 5'(best)});
        end
    endfunction

    task automatic send_frame(input int n, input bit use_last);
        int g;
        send_to = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_value = fv[i];
            in_last  = use_last && (i == n - 1);
            g = 0;
            while (!in_ready && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) send_to = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,..., 2: random ready
    task automatic collect(input int mode);
        bit          held;
        logic [12:0] hd;
        held = 1'b0;
        hd = '0;
        got_q.delete();
        last_pos = -1;
        stall_err = 0;
        drain_to = 1'b1;
        for (int c = 0; c < 400; c++) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
            if (held && (!out_valid || out_data !== hd)) stall_err++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (out_last) last_pos = got_q.size() - 1;
                held = 1'b0;
            end else if (out_valid) begin
                held = 1'b1;
                hd = out_data;
            end
            @(negedge clk);
            if (last_pos >= 0) begin
                drain_to = 1'b0;
                break;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_value = 8'sd55;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_data !== 13'd0) begin n_err++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed_frame();
        logic [7:0] v [8] = '{8'sd5, -8'sd3, 8'sd12, 8'sd7, 8'sd12, 8'sd0, 8'sd9, -8'sd128};
        for (int i = 0; i < 8; i++) fv[i] = v[i];
        build_expected(8);
        send_frame(8, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir_latency out_valid got=%b want=1", out_valid); end
        collect(0);
        n_cmp++; if (drain_to || got_q.size() != 6) begin n_err++; $display("FAIL dir_count got=%0d want=6", got_q.size()); end
        n_cmp++; if (got_q.size() > 0 && got_q[0] !== {8'd12, 5'd2}) begin n_err++; $display("FAIL dir_first got=%h want=%h", got_q[0], {8'd12, 5'd2}); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++; if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL dir_word%0d got=%h want=%h", k, (k < got_q.size()) ? got_q[k] : 13'h1fff, exp_q[k]); end
        end
        n_cmp++; if (last_pos != 5) begin n_err++; $display("FAIL dir_last_pos got=%0d want=5", last_pos); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir_turnaround in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_ties();
        fv[0] = -8'sd1; fv[1] = -8'sd2; fv[2] = -8'sd1;
        build_expected(3);
        send_frame(3, 1'b1);
        collect(0);
        n_cmp++; if (drain_to || got_q.size() != 3) begin n_err++; $display("FAIL ties_count got=%0d want=3", got_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++; if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL ties_word%0d got=%h want=%h", k, (k < got_q.size()) ? got_q[k] : 13'h1fff, exp_q[k]); end
        end
        n_cmp++; if (last_pos != 2) begin n_err++; $display("FAIL ties_last_pos got=%0d want=2", last_pos); end
    endtask

    task automatic test_forced_last();
        for (int i = 0; i < 32; i++) fv[i] = 8'(i);
        build_expected(32);
        send_frame(32, 1'b0);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL forced_in_ready got=%b want=0", in_ready); end
        collect(0);
        n_cmp++; if (drain_to || got_q.size() != 6) begin n_err++; $display("FAIL forced_count got=%0d want=6", got_q.size()); end
        n_cmp++; if (got_q.size() > 5 && got_q[5] !== {8'd26, 5'd26}) begin n_err++; $display("FAIL forced_tail got=%h want=%h", got_q[5], {8'd26, 5'd26}); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++; if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL forced_word%0d got=%h want=%h", k, (k < got_q.size()) ? got_q[k] : 13'h1fff, exp_q[k]); end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 10; i++) fv[i] = 8'($urandom);
        build_expected(10);
        send_frame(10, 1'b1);
        collect(1);
        n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL stall_hold got=%0d want=0", stall_err); end
        n_cmp++; if (drain_to || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL stall_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++; if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL stall_word%0d got=%h want=%h", k, (k < got_q.size()) ? got_q[k] : 13'h1fff, exp_q[k]); end
        end
    endtask

    task automatic test_reset_mid_drain();
        fv[0] = 8'sd4; fv[1] = 8'sd9; fv[2] = -8'sd7;
        send_frame(3, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstdrain_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstdrain_in_ready got=%b want=1", in_ready); end
        fv[0] = 8'sd100;
        send_frame(1, 1'b1);
        collect(0);
        n_cmp++; if (drain_to || got_q.size() != 1 || got_q[0] !== {8'd100, 5'd0}) begin n_err++; $display("FAIL rstdrain_word got=%h n=%0d want=%h", (got_q.size() > 0) ? got_q[0] : 13'h1fff, got_q.size(), {8'd100, 5'd0}); end
        n_cmp++; if (last_pos != 0) begin n_err++; $display("FAIL rstdrain_last_pos got=%0d want=0", last_pos); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) fv[i] = 8'($urandom);
        build_expected(4);
        send_frame(4, 1'b1);
        in_valid = 1'b1;
        in_value = 8'sd77;
        in_last  = 1'b1;
        collect(0);
        n_cmp++; if (drain_to || got_q.size() != 4) begin n_err++; $display("FAIL b2b_count got=%0d want=4", got_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++; if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL b2b_word%0d got=%h want=%h", k, (k < got_q.size()) ? got_q[k] : 13'h1fff, exp_q[k]); end
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== {8'd77, 5'd0} || out_last !== 1'b1) begin n_err++; $display("FAIL b2b_frame2 got=%b/%h/%b want=1/%h/1", out_valid, out_data, out_last, {8'd77, 5'd0}); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_end_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_random();
        int n;
        bit ul;
        for (int f = 0; f < 20; f++) begin
            n = $urandom_range(1, 32);
            ul = (n < 32) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) fv[i] = 8'($urandom_range(0, 6) - 3);
                else fv[i] = 8'($urandom);
            end
            build_expected(n);
            send_frame(n, ul);
            n_cmp++; if (send_to) begin n_err++; $display("FAIL rnd%0d_send_timeout got=1 want=0", f); end
            collect(2);
            n_cmp++; if (drain_to || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd%0d_count got=%0d want=%0d", f, got_q.size(), exp_q.size()); end
            n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL rnd%0d_hold got=%0d want=0", f, stall_err); end
            for (int k = 0; k < exp_q.size(); k++) begin
                n_cmp++; if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rnd%0d_word%0d got=%h want=%h", f, k, (k < got_q.size()) ? got_q[k] : 13'h1fff, exp_q[k]); end
            end
            n_cmp++; if (last_pos != exp_q.size() - 1) begin n_err++; $display("FAIL rnd%0d_last_pos got=%0d want=%0d", f, last_pos, exp_q.size() - 1); end
        end
    endtask

    initial begin
        test_reset();
        test_directed_frame();
        test_ties();
        test_forced_last();
        test_stall();
        test_reset_mid_drain();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
